// File: rtl/ddr_stream_fifo.sv
// Synchronous FIFO between the I_DDR capture and O_DDR drive stages (optional macro DDR_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow).
// Latency: rd_data/rd_valid registered one edge after an accepted rd_en; status flags follow the registered pointers.
// Backpressure: writes while full and reads while empty are dropped; full/empty must be observed by the producer/consumer.
module ddr_stream_fifo #(
    parameter int DATA_WIDTH   = 2,
    parameter int DEPTH        = 256,
    parameter int AFULL_LEVEL  = DEPTH - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef DDR_FIFO_ERR_FLAGS_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LEVEL);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LEVEL);
    localparam logic [AW:0] PTR_INC  = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // The extra wrap bit makes the modular difference span 0..DEPTH without ambiguity.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_INC;
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + PTR_INC;
            end
        end
    end

`ifdef DDR_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_stream_fifo.sv
// Bench for ddr_stream_fifo at DEPTH=8: directed vector table, wrap-around run and randomized traffic against a queue model.
module tb_ddr_stream_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_data;
    logic       rd_en;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
`ifdef DDR_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_stream_fifo #(
        .DATA_WIDTH  (2),
        .DEPTH       (8),
        .AFULL_LEVEL (6),
        .AEMPTY_LEVEL(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count)
`ifdef DDR_FIFO_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    typedef struct {
        logic       rst;
        logic       we;
        logic [1:0] wd;
        logic       re;
        int         cnt;
        logic       rv;
        logic [1:0] rd;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tab[$];

    // Reference model state
    logic [1:0] q[$];
    logic [1:0] m_rd;
    logic       m_rv;
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int cnt, input logic rv,
                                 input logic [1:0] rd, input logic ovf, input logic unf);
        chk({tag, ".count"},        int'(count),        cnt);
        chk({tag, ".rd_valid"},     int'(rd_valid),     int'(rv));
        chk({tag, ".rd_data"},      int'(rd_data),      int'(rd));
        chk({tag, ".full"},         int'(full),         int'(cnt == 8));
        chk({tag, ".empty"},        int'(empty),        int'(cnt == 0));
        chk({tag, ".almost_full"},  int'(almost_full),  int'(cnt >= 6));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(cnt <= 2));
`ifdef DDR_FIFO_ERR_FLAGS_EN
        chk({tag, ".overflow"},     int'(overflow),     int'(ovf));
        chk({tag, ".underflow"},    int'(underflow),    int'(unf));
`else
        if (ovf !== unf && 1'b0) $display("unused");
`endif
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] d, input logic rr);
        reset   = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rr;
        @(posedge clk);
        #1;
    endtask

    // Queue model: both requests judged against pre-edge occupancy; pop happens before push.
    task automatic step(input logic r, input logic w, input logic [1:0] d, input logic rr, input string tag);
        int n;
        n = q.size();
        if (r) begin
            q.delete();
            m_rd = 2'd0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (w && n == 8) m_ovf = 1'b1;
            if (rr && n == 0) m_unf = 1'b1;
            m_rv = 1'b0;
            if (rr && n != 0) begin
                m_rd = q.pop_front();
                m_rv = 1'b1;
            end
            if (w && n != 8) q.push_back(d);
        end
        drive(r, w, d, rr);
        check_outputs(tag, q.size(), m_rv, m_rd, m_ovf, m_unf);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 2'd0; rd_en = 1'b0;

        // rst we wd re | cnt rv rd ovf unf
        tab.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 0, 1'b0, 2'd0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++)
            tab.push_back('{1'b0, 1'b1, 2'(i % 4), 1'b0, i + 1, 1'b0, 2'd0, 1'b0, 1'b0});
        // full: simultaneous write of 3 dropped, oldest word 0 read
        tab.push_back('{1'b0, 1'b1, 2'd3, 1'b1, 7, 1'b1, 2'd0, 1'b1, 1'b0});
        for (int i = 1; i < 8; i++)
            tab.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 7 - i, 1'b1, 2'(i % 4), 1'b1, 1'b0});
        // empty: write of 2 accepted, read dropped, no fall-through
        tab.push_back('{1'b0, 1'b1, 2'd2, 1'b1, 1, 1'b0, 2'd3, 1'b1, 1'b1});
        tab.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 0, 1'b1, 2'd2, 1'b1, 1'b1});
        tab.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b0, 2'd2, 1'b1, 1'b1});
        for (int i = 0; i < 5; i++)
            tab.push_back('{1'b0, 1'b1, 2'd1, 1'b0, i + 1, 1'b0, 2'd2, 1'b1, 1'b1});
        // reset wins over a concurrent write
        tab.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 0, 1'b0, 2'd0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++)
            tab.push_back('{1'b0, 1'b1, 2'(i + 1), 1'b0, i + 1, 1'b0, 2'd0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++)
            tab.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 2 - i, 1'b1, 2'(i + 1), 1'b0, 1'b0});

        foreach (tab[i]) begin
            drive(tab[i].rst, tab[i].we, tab[i].wd, tab[i].re);
            check_outputs($sformatf("vec%0d", i), tab[i].cnt, tab[i].rv, tab[i].rd, tab[i].ovf, tab[i].unf);
        end

        // Wrap-around: hold occupancy at 3 across several pointer wraps
        step(1'b1, 1'b0, 2'd0, 1'b0, "wrap_rst");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, "wrap_fill");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b1, "wrap");
            chk("wrap_hold_cnt", int'(count), 3);
        end

        // Randomized traffic with alternating fill/drain bias and rare resets
        for (int i = 0; i < 800; i++) begin
            logic w, rr, r;
            int wp;
            wp = ((i / 40) % 2 == 0) ? 75 : 25;
            w  = ($urandom_range(0, 99) < wp);
            rr = ($urandom_range(0, 99) < 100 - wp);
            r  = ($urandom_range(0, 149) == 0);
            step(r, w, 2'($urandom_range(0, 3)), rr, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_stream_fifo.md
# ddr_stream_fifo

Parametrised synchronous FIFO between an `I_DDR` capture stage and an `O_DDR` drive stage, buffering one DDR word pair per accepted beat. It is the next generation of the team's 2-bit, 256-deep DDR loopback FIFO. It adds:
- configurable width and depth;
- correct wrap-around using an extra pointer bit;
- occupancy count and programmable almost-full/almost-empty levels;
- a registered read-valid strobe;
- optional sticky overflow/underflow error flags.

## Interface
Parameters:
- `DATA_WIDTH`, default 2: width of one FIFO word; 2 matches a single I_DDR/O_DDR pin pair.
- `DEPTH`, default 256: number of entries; must be a power of two, at least 4.
- `AFULL_LEVEL`, default DEPTH-4: `almost_full` asserts when count is at or above this level.
- `AEMPTY_LEVEL`, default 4: `almost_empty` asserts when count is at or below this level.

Ports (AW = $clog2(DEPTH)):
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: write request.
- `wr_data`  in  DATA_WIDTH: write word.
- `rd_en`  in  1: read request.
- `rd_data`  out  DATA_WIDTH: registered read word.
- `rd_valid`  out  1: `rd_data` was loaded on this edge.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `almost_full`  out  1: count >= AFULL_LEVEL.
- `almost_empty`  out  1: count <= AEMPTY_LEVEL.
- `count`  out  AW+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag; present only with DDR_FIFO_ERR_FLAGS_EN.
- `underflow`  out  1: sticky flag; present only with DDR_FIFO_ERR_FLAGS_EN.

## Operation
- Storage: DEPTH x DATA_WIDTH array.
- Pointers: `wr_ptr` and `rd_ptr`, each AW+1 bits.
  - The low AW bits address the array.
  - The MSB is the wrap bit.
  - Pointers increment modulo 2^(AW+1); they are never compared to DEPTH-1.
- count = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
- Write accept: `wr_en` && !`full`.
  - Stores `wr_data` at wr_ptr[AW-1:0].
  - Increments wr_ptr.
- Read accept: `rd_en` && !`empty`.
  - Loads `rd_data` from rd_ptr[AW-1:0].
  - Increments rd_ptr.
  - Sets `rd_valid` = 1 for the following cycle.
- Rejected requests do not change pointers, memory or `rd_data`.
- Simultaneous read and write:
  - Both requests are judged against the pre-edge `full`/`empty`.
  - When neither flag is set, both are accepted and count is unchanged.
  - When full, only the read is accepted; the write is dropped.
  - When empty, only the write is accepted; the read is dropped. No fall-through: the new word is not visible on `rd_data` that cycle.
- `rd_data` holds its last loaded value until the next accepted read.
- Reset (synchronous, can occur mid-operation):
  - Clears both pointers; memory contents are not cleared.
  - Output values after reset:
    - `rd_data` = 0, `rd_valid` = 0.
    - count = 0, `empty` = 1, `full` = 0.
    - `almost_empty` = 1, `almost_full` = 0.
    - `overflow` = 0, `underflow` = 0.
  - Reset has priority over `wr_en`/`rd_en` in the same cycle.

## Timing
- All status outputs are decoded from the registered pointers. They reflect an accepted operation on the cycle after the accepting edge; there is no combinational path from `wr_en`/`rd_en`.
- Read latency: `rd_en` sampled at edge N; `rd_data` and `rd_valid` are valid after edge N.
- Write-to-read latency: a word written at edge N can be read-accepted at edge N+1 at the earliest, when `empty` drops.
- Throughput: one write and one read per cycle sustained.

## Configuration
- `DDR_FIFO_ERR_FLAGS_EN` defined: the `overflow` and `underflow` ports and their logic exist.
  - `overflow` sets on any edge with `wr_en` && `full`.
  - `underflow` sets on any edge with `rd_en` && `empty`.
  - Both flags are sticky and clear only on `reset`.
- `DDR_FIFO_ERR_FLAGS_EN` undefined: the ports are absent. Dropped requests are silently ignored; all other behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=2, DEPTH=8, AFULL_LEVEL=6, AEMPTY_LEVEL=2.
- Fill and drain:
  - Write 0,1,2,3,0,1,2,3 on consecutive cycles: `full`=1 and count=8 after the 8th edge; `almost_full` asserts after the 6th edge.
  - Read 8 beats: `rd_data` sequence 0,1,2,3,0,1,2,3 with `rd_valid`=1 each cycle; `empty`=1 after the last read.
- Wrap-around: run 20 cycles of simultaneous write/read with count held at 3. Data order is preserved across the pointer wrap; count stays 3 and `full` never asserts.
- Full boundary: with the FIFO full, assert `wr_en`+`rd_en` with `wr_data`=3.
  - Count drops to 7 and the read returns the oldest word.
  - Word 3 is not stored; with the macro defined, `overflow`=1 and stays set.
- Empty boundary: with the FIFO empty, assert `wr_en`+`rd_en` with `wr_data`=2.
  - `rd_valid`=0 and count becomes 1.
  - The next read returns 2; with the macro defined, `underflow`=1.
- Reset mid-operation: with count=5, assert `reset` together with `wr_en`. The next cycle shows count=0, `empty`=1, `rd_valid`=0, `rd_data`=0, and the error flags cleared.
- Almost levels: step count 0 to 3 and back. `almost_empty` is 1 at counts 0-2 and 0 at count 3, each change appearing one cycle after the accepting edge.
